// File: rtl/sprite_layer_if.sv
// sprite_layer_if: texel ROM read bus between the sprite renderer and its texel ROM
//   rd   : read strobe, one texel per clk
//   addr : texel address = row*WIDTH + col
//   data : texel {R[12:9], G[8:5], B[4:1], opaque[0]}, valid one clk after rd
//   master modport -> sprite_layer, slave modport -> ROM
interface sprite_layer_if #(
    parameter int AW = 8
);
    logic          rd;
    logic [AW-1:0] addr;
    logic [12:0]   data;
    modport master (output rd, addr, input data);
    modport slave  (input rd, addr, output data);
endinterface

// File: rtl/sprite_layer.sv
// sprite_layer: line-buffered sprite renderer producing one RGBA compositor layer
//   clk, rst          : pixel clock, asynchronous active-high reset
//   hdata, vdata      : current column / line from the vga timing block
//   valid             : active-video flag
//   sprite_en         : layer enable
//   sprite_x/sprite_y : sprite top-left screen position
//   mirror_x          : horizontal flip (only when SPRITE_MIRROR_EN is defined)
//   rom               : texel ROM read bus (sprite_layer_if.master)
//   R, G, B, A        : registered layer colour and alpha, 1 clk after hdata
// Optional feature macro: SPRITE_MIRROR_EN
module sprite_layer #(
    parameter int WIDTH      = 16,
    parameter int HEIGHT     = 16,
    parameter int SCALE_LOG2 = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [11:0]           hdata,
    input  logic [11:0]           vdata,
    input  logic                  valid,
    input  logic                  sprite_en,
    input  logic [11:0]           sprite_x,
    input  logic [11:0]           sprite_y,
`ifdef SPRITE_MIRROR_EN
    input  logic                  mirror_x,
`endif
    sprite_layer_if.master        rom,
    output logic [3:0]            R,
    output logic [3:0]            G,
    output logic [3:0]            B,
    output logic                  A
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state, state_nx;

    logic [RW-1:0] row;
    logic [CW-1:0] k, wr_idx, col, col_eff;
    logic          back_vld, front_vld, wr_en, sel;
    logic [11:0]   front_x, next_line;
    logic [12:0]   dy, dx, texel;
    logic          line_hit, col_hit;
    logic [12:0]   line_buf [2][WIDTH];

    // Sprite position relative to the line being prepared and the pixel being drawn;
    // bit 12 is the sign, so lines/columns before the sprite never count as hits.
    assign next_line = (vdata == 12'(V_TOTAL - 1)) ? 12'd0 : vdata + 12'd1;
    assign dy        = {1'b0, next_line} - {1'b0, sprite_y};
    assign line_hit  = sprite_en && !dy[12] && dy[11:0] < 12'(HEIGHT << SCALE_LOG2);
    assign dx        = {1'b0, hdata} - {1'b0, front_x};
    assign col_hit   = !dx[12] && dx[11:0] < 12'(WIDTH << SCALE_LOG2);
    assign col       = dx[SCALE_LOG2 +: CW];

`ifdef SPRITE_MIRROR_EN
    logic front_mirror;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            front_mirror <= 1'b0;
        else if (hdata == 12'(H_TOTAL - 1))
            front_mirror <= mirror_x;
    // WIDTH is a power of two, so WIDTH-1-col is a bitwise invert
    assign col_eff = front_mirror ? ~col : col;
`else
    assign col_eff = col;
`endif

    // sel picks the front half; the back half is the other one, so a swap is a toggle
    assign texel = line_buf[sel][col_eff];

    always_comb begin
        state_nx = (state == IDLE && hdata == 12'(H_ACTIVE) && line_hit) ? FETCH :
                   (state == FETCH && &k)                                ? DRAIN :
                   (state == DRAIN)                                      ? IDLE  : state;
        rom.rd   = state == FETCH;
        rom.addr = (state == FETCH) ? {row, k} : '0;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            k         <= '0;
            wr_en     <= 1'b0;
            wr_idx    <= '0;
            back_vld  <= 1'b0;
            front_vld <= 1'b0;
            front_x   <= '0;
            sel       <= 1'b0;
            {R, G, B, A} <= 13'd0;
        end else begin
            state  <= state_nx;
            // ROM answers one clk after the strobe, so the write trails the read by one
            wr_en  <= state == FETCH;
            wr_idx <= k;
            if (state == IDLE && hdata == 12'(H_ACTIVE)) begin
                row      <= dy[SCALE_LOG2 +: RW];
                k        <= '0;
                back_vld <= 1'b0;
            end
            if (state == FETCH)
                k <= k + 1'b1;
            if (state == DRAIN)
                back_vld <= 1'b1;
            if (hdata == 12'(H_TOTAL - 1)) begin
                sel       <= ~sel;
                front_vld <= back_vld;
                front_x   <= sprite_x;
            end
            {R, G, B, A} <= (valid && front_vld && col_hit) ? texel : 13'd0;
        end

    always_ff @(posedge clk)
        if (wr_en)
            line_buf[~sel][wr_idx] <= rom.data;
endmodule

// File: tb/tb_sprite_layer.sv
// tb_sprite_layer: self-checking bench for sprite_layer with a line-level reference model
module tb_sprite_layer;
    localparam int HA = 180;
    localparam int HT = 200;
    localparam int VT = 80;

`ifdef SPRITE_MIRROR_EN
    localparam logic [12:0] E100 = 31, E104 = 28, E163 = 0, E73A = 511, E73B = 508;
    localparam logic [12:0] E74 = 28, E79 = 63, E140 = 11, E134 = 28, E32 = 188;
`else
    localparam logic [12:0] E100 = 0, E104 = 3, E163 = 31, E73A = 480, E73B = 483;
    localparam logic [12:0] E74 = 3, E79 = 32, E140 = 20, E134 = 3, E32 = 163;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic [11:0] hdata = '0, vdata = '0, sprite_x = '0, sprite_y = '0;
    logic        valid = 1'b0, sprite_en = 1'b0, mirror_x = 1'b0;
    logic [3:0]  R, G, B;
    logic        A;
    logic [12:0] mem [256];

    sprite_layer_if #(.AW(8)) bus ();

    sprite_layer #(
        .WIDTH(16), .HEIGHT(16), .SCALE_LOG2(2),
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .rst(rst), .hdata(hdata), .vdata(vdata), .valid(valid),
        .sprite_en(sprite_en), .sprite_x(sprite_x), .sprite_y(sprite_y),
`ifdef SPRITE_MIRROR_EN
        .mirror_x(mirror_x),
`endif
        .rom(bus), .R(R), .G(G), .B(B), .A(A)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.rd)
            bus.data <= mem[bus.addr];

    int checks = 0, errors = 0, rd_cnt = 0;
    logic [11:0] ph = '0, pv = '0;

    bit          disp_vld, pend_vld, disp_mir;
    int          disp_row, pend_row, disp_x;
    logic [12:0] exp_px;
    bit          exp_rd;
    logic [7:0]  exp_addr;
    int          aq[$];

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s line %0d hdata %0d: got %0h want %0h", name, pv, ph, got, want);
        end
    endtask

    task automatic model_reset();
        disp_vld = 0; pend_vld = 0; exp_px = '0; exp_rd = 0; exp_addr = '0;
        aq.delete();
    endtask

    task automatic model_edge();
        int dx, dy, nl, col;
        if (rst) begin
            model_reset();
            return;
        end
        dx = int'(hdata) - disp_x;
        if (valid && disp_vld && dx >= 0 && dx < 64) begin
            col = dx / 4;
            if (disp_mir) col = 15 - col;
            exp_px = mem[disp_row * 16 + col];
        end else
            exp_px = '0;
        if (int'(hdata) == HA) begin
            nl = (int'(vdata) == VT - 1) ? 0 : int'(vdata) + 1;
            dy = nl - int'(sprite_y);
            pend_vld = sprite_en && dy >= 0 && dy < 64;
            pend_row = dy / 4;
            if (pend_vld)
                for (int i = 0; i < 16; i++) aq.push_back(pend_row * 16 + i);
        end
        exp_rd = aq.size() != 0;
        exp_addr = '0;
        if (exp_rd) exp_addr = 8'(aq.pop_front());
        if (int'(hdata) == HT - 1) begin
            disp_vld = pend_vld; disp_row = pend_row;
            disp_x = int'(sprite_x); disp_mir = mirror_x;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        ph = hdata;
        pv = vdata;
        #1;
        if (bus.rd === 1'b1) rd_cnt++;
        if (int'(hdata) == HT - 1) begin
            hdata = '0;
            vdata = (int'(vdata) == VT - 1) ? 12'd0 : vdata + 12'd1;
        end else
            hdata = hdata + 12'd1;
        valid = int'(hdata) < HA;
        @(negedge clk);
        chk("rgba", {R, G, B, A}, exp_px);
        chk("rom_rd", bus.rd, exp_rd);
        chk("rom_addr", bus.addr, exp_addr);
    endtask

    task automatic run_to(int tv, int th);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(int'(pv) == tv && int'(ph) == th) && n < 2 * VT * HT);
        chk("run_to_pos", pv * 1000 + ph, tv * 1000 + th);
    endtask

    task automatic lit(string name, int tv, int th, logic [12:0] want);
        run_to(tv, th);
        chk(name, {R, G, B, A}, want);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 13'({i[11:0], i[0]});
        model_reset();
        hdata = 12'(HT - 3); vdata = 12'(VT - 1);
        sprite_en = 1; sprite_x = 100; sprite_y = 10;
        repeat (3) step();
        rst = 0;
        rd_cnt = 0;
        // basic hit and vertical bounds
        lit("above_top", 9, 120, 0);
        lit("left_of_sprite", 10, 99, 0);
        lit("first_texel", 10, 100, E100);
        lit("first_texel_end", 10, 103, E100);
        lit("second_texel", 10, 104, E104);
        lit("second_texel_end", 10, 107, E104);
        lit("last_column", 10, 163, E163);
        lit("right_of_sprite", 10, 164, 0);
        lit("bottom_row_a", 73, 100, E73A);
        lit("bottom_row_b", 73, 104, E73B);
        lit("below_bottom", 74, 120, 0);
        run_to(79, 199);
        chk("rd_per_frame", rd_cnt, 1024);
        // clip at the bottom, no wrap to line 0
        sprite_y = 74;
        rd_cnt = 0;
        lit("clip_row0", 74, 104, E74);
        lit("clip_row1", 79, 100, E79);
        run_to(79, 199);
        chk("rd_clip_frame", rd_cnt, 96);
        lit("no_wrap_line0", 0, 104, 0);
        // mid-line move
        sprite_y = 10;
        run_to(10, 120);
        sprite_x = 130;
        lit("old_x_holds", 10, 140, E140);
        lit("new_x_old_pos", 11, 104, 0);
        lit("new_x_applies", 11, 134, E134);
        // reset in the middle of a fetch
        run_to(30, 185);
        chk("fetch_rd", bus.rd, 1);
        chk("fetch_addr", bus.addr, 85);
        rst = 1;
        #1;
        chk("rst_rd", bus.rd, 0);
        chk("rst_rgba", {R, G, B, A}, 0);
        model_reset();
        repeat (2) step();
        rst = 0;
        lit("after_rst_line", 31, 134, 0);
        lit("recovered_line", 32, 134, E32);
        // disabled for a full frame
        sprite_en = 0;
        run_to(79, 199);
        rd_cnt = 0;
        run_to(79, 199);
        chk("rd_disabled", rd_cnt, 0);
        // random contents and positions
        rst = 1;
        model_reset();
        for (int i = 0; i < 256; i++) mem[i] = 13'($urandom);
        repeat (2) step();
        rst = 0;
        sprite_en = 1;
        for (int n = 0; n < 12000; n++) begin
            step();
            if ($urandom_range(0, 299) == 0) begin
                sprite_x = 12'($urandom_range(0, 200));
                sprite_y = 12'($urandom_range(0, VT - 1));
                sprite_en = $urandom_range(0, 3) != 0;
`ifdef SPRITE_MIRROR_EN
                mirror_x = 1'($urandom_range(0, 1));
`endif
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
